// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one combinational sprite bitmap ROM among
// NUM_REQ renderers; each grant runs IDLE -> FETCH -> DONE (3 cycles).
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IMG_W   = 2,
  parameter int ROW_W   = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*IMG_W-1:0]   req_img,
  input  logic [NUM_REQ*ROW_W-1:0]   req_row,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rd_data,
  output logic [IMG_W+ROW_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]          rom_bits,
  output logic                       busy
);

  // Handshake: a requester holds req high with img/row stable until it sees
  // its one-cycle ack, and drops req at that edge. Address is captured only
  // at the IDLE grant edge; a req still high back in IDLE is a new request.

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W:0]   NUM_REQ_X = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W:0]   scan;
  logic [IMG_W-1:0] win_img;
  logic [ROW_W-1:0] win_row;

  // Scan upward from rr_ptr, wrapping at NUM_REQ (not at a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan >= NUM_REQ_X) scan = scan - NUM_REQ_X;
      if (!found && req[scan[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_img = req_img[int'(winner)*IMG_W +: IMG_W];
    win_row = req_row[int'(winner)*ROW_W +: ROW_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ack      <= '0;
      rd_data  <= '0;
      rom_addr <= '0;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt_idx  <= winner;
            rom_addr <= {win_img, win_row};
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_data <= rom_bits;
          ack     <= NUM_REQ'(1) << gnt_idx;
          busy    <= 1'b0;
          state   <= S_DONE;
        end
        S_DONE: begin
          ack    <= '0;
          rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a 4-requester instance plus a
// 3-requester instance for the non-power-of-two wrap.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RW = 4;
  localparam int DW = 8;
  localparam int AW = IW + RW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [N-1:0]    req;
  logic [N*IW-1:0] req_img;
  logic [N*RW-1:0] req_row;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rd_data;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_bits;
  logic            busy;

  logic [2:0]      req3;
  logic [3*IW-1:0] req_img3;
  logic [3*RW-1:0] req_row3;
  logic [2:0]      ack3;
  logic [DW-1:0]   rd_data3;
  logic [AW-1:0]   rom_addr3;
  logic [DW-1:0]   rom_bits3;
  logic            busy3;

  // ROM contents: word = {2'b10, addr}, so address 0x25 holds 0xA5
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {2'b10, a};
  endfunction

  assign rom_bits  = rom_word(rom_addr);
  assign rom_bits3 = rom_word(rom_addr3);

  sprite_rom_arbiter #(.NUM_REQ(N), .IMG_W(IW), .ROW_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_img(req_img), .req_row(req_row),
    .ack(ack), .rd_data(rd_data), .rom_addr(rom_addr), .rom_bits(rom_bits),
    .busy(busy)
  );

  sprite_rom_arbiter #(.NUM_REQ(3), .IMG_W(IW), .ROW_W(RW), .DATA_W(DW)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_img(req_img3), .req_row(req_row3),
    .ack(ack3), .rd_data(rd_data3), .rom_addr(rom_addr3), .rom_bits(rom_bits3),
    .busy(busy3)
  );

  int checks = 0;
  int errors = 0;
  logic [DW+N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [IW-1:0] img, input logic [RW-1:0] row);
    req_img[i*IW +: IW] = img;
    req_row[i*RW +: RW] = row;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Raise r, wait (bounded) for the ack, check it against exp_idx, then drop
  // that requester and step through DONE.
  task automatic run_fetch(input logic [N-1:0] r, input int exp_idx, input string tag);
    logic [AW-1:0] exp_addr;
    int n;
    req = r;
    exp_addr = {req_img[exp_idx*IW +: IW], req_row[exp_idx*RW +: RW]};
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < 6);
    check({tag, " ack"}, 32'(ack), 32'(1) << exp_idx);
    check({tag, " rd_data"}, 32'(rd_data), 32'(rom_word(exp_addr)));
    check({tag, " rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    req[exp_idx] = 1'b0;
    step();
    check({tag, " ack clear"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int cyc, last, acks, idx;
    int reraise[N];
    logic [DW+N-1:0] exp_v;

    req = '0; req_img = '0; req_row = '0;
    req3 = '0; req_img3 = '0; req_row3 = '0;

    // reset then idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      check("idle ack", 32'(ack), 32'd0);
      check("idle busy", 32'(busy), 32'd0);
      check("idle rom_addr", 32'(rom_addr), 32'd0);
      check("idle rd_data", 32'(rd_data), 32'd0);
      step();
    end

    // single fetch: requester 0, img 2 row 5 -> addr 0x25 -> 0xA5
    set_addr(0, 2'd2, 4'd5);
    req = 4'b0001;
    step();
    check("single rom_addr", 32'(rom_addr), 32'h25);
    check("single busy", 32'(busy), 32'd1);
    check("single ack early", 32'(ack), 32'd0);
    step();
    check("single ack", 32'(ack), 32'b0001);
    check("single rd_data", 32'(rd_data), 32'hA5);
    check("single busy low", 32'(busy), 32'd0);
    req = 4'b0000;
    step();
    check("single ack one cycle", 32'(ack), 32'd0);
    check("single rd_data held", 32'(rd_data), 32'hA5);

    // round-robin with all requesters, re-raising 2 cycles after each ack
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, IW'(i), RW'(i * 3 + 1));
    foreach (exp_q[k]) exp_q.delete(k);
    for (int g = 0; g < 6; g++) begin
      idx = g % N;
      exp_q.push_back({N'(1) << idx, rom_word({IW'(idx), RW'(idx * 3 + 1)})});
    end
    for (int i = 0; i < N; i++) reraise[i] = -1;
    req = '1; cyc = 0; last = -1; acks = 0;
    while (acks < 6 && cyc < 40) begin
      step();
      cyc++;
      for (int i = 0; i < N; i++) if (reraise[i] == cyc) req[i] = 1'b1;
      if (ack != '0) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rr ack/data", 32'({ack, rd_data}), 32'(exp_v));
        if (last >= 0) check("rr gap", 32'(cyc - last), 32'd3);
        last = cyc;
        acks++;
        for (int i = 0; i < N; i++) if (ack[i]) reraise[i] = cyc + 2;
        req = req & ~ack;
      end
    end
    check("rr ack count", 32'(acks), 32'd6);
    req = '0;
    step();
    step();
    check("rr busy after", 32'(busy), 32'd0);

    // pointer wrap: after grant to 2, req 1001 -> 3 before 0
    run_fetch(4'b0100, 2, "wrap g2");
    run_fetch(4'b1001, 3, "wrap g3");
    run_fetch(4'b0001, 0, "wrap g0");

    // three-requester instance: after grant to 2, req 011 -> 0 next
    req_img3 = {2'd3, 2'd1, 2'd2};
    req_row3 = {4'hE, 4'h6, 4'h9};
    req3 = 3'b100;
    step();
    check("n3 addr2", 32'(rom_addr3), 32'h3E);
    step();
    check("n3 ack2", 32'(ack3), 32'b100);
    check("n3 data2", 32'(rd_data3), 32'(rom_word(6'h3E)));
    req3 = 3'b011;
    step();
    step();
    check("n3 addr0", 32'(rom_addr3), 32'h29);
    step();
    check("n3 ack0", 32'(ack3), 32'b001);
    check("n3 data0", 32'(rd_data3), 32'(rom_word(6'h29)));
    req3 = '0;
    step();

    // address stability and abandon: requester 0, addr 0x17
    set_addr(0, 2'd1, 4'd7);
    req = 4'b0001;
    step();
    check("abandon rom_addr", 32'(rom_addr), 32'h17);
    set_addr(0, 2'd1, 4'hC);
    req = 4'b0000;
    step();
    check("abandon ack", 32'(ack), 32'b0001);
    check("abandon rd_data", 32'(rd_data), 32'(rom_word(6'h17)));
    for (int c = 0; c < 5; c++) begin
      step();
      check("abandon no regrant", 32'({busy, ack}), 32'd0);
      check("abandon rd_data held", 32'(rd_data), 32'(rom_word(6'h17)));
    end

    // reset mid-fetch
    req = 4'b0100;
    step();
    check("midrst busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst ack", 32'(ack), 32'd0);
    check("midrst rd_data", 32'(rd_data), 32'd0);
    check("midrst rom_addr", 32'(rom_addr), 32'd0);
    check("midrst busy low", 32'(busy), 32'd0);
    step();
    check("midrst ack held", 32'(ack), 32'd0);
    req = 4'b0101;
    reset = 1'b0;
    run_fetch(4'b0101, 0, "postrst g0");
    run_fetch(4'b0100, 2, "postrst g2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
